// File: rtl/fb_req_client.sv
// Requester agent for the frame-buffer round-robin arbiter: queues burst commands,
// holds request until grant, streams beats. Optional starvation timer via FB_REQ_TIMEOUT_EN.
module fb_req_client #(
    parameter int AW        = 20,
    parameter int LW        = 8,
    parameter int DEPTH     = 4,
    parameter int TO_CYCLES = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_addr,
    input  logic [LW-1:0] cmd_len,
    output logic          request,
    input  logic          grant,
    output logic          mem_valid,
    output logic [AW-1:0] mem_addr,
    output logic          mem_last,
    input  logic          mem_ready,
    output logic          busy,
    output logic          starve
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   PTR_ONE  = 1;
    localparam logic [AW-1:0] ADDR_ONE = 1;
    localparam logic [LW-1:0] LEN_ONE  = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_reg;
    logic [PW:0]   wr_ptr_reg;
    logic [PW:0]   rd_ptr_reg;
    logic [AW-1:0] fifo_addr [DEPTH];
    logic [LW-1:0] fifo_len  [DEPTH];
    logic [AW-1:0] addr_reg;
    logic [LW-1:0] beats_left_reg;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          beat;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                        (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && !fifo_full;
    assign pop        = (state_reg == IDLE) && !fifo_empty;
    assign beat       = mem_valid && mem_ready;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg[PW-1:0] == PW'(gi))) begin
                    fifo_addr[gi] <= cmd_addr;
                    fifo_len[gi]  <= cmd_len;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            beats_left_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!fifo_empty) begin
                        addr_reg       <= fifo_addr[rd_ptr_reg[PW-1:0]];
                        beats_left_reg <= fifo_len[rd_ptr_reg[PW-1:0]];
                        state_reg      <= REQ;
                    end
                end
                REQ: begin
                    if (grant) state_reg <= BURST;
                end
                BURST: begin
                    // Losing grant simply stalls beats; position is kept.
                    if (beat) begin
                        addr_reg       <= addr_reg + ADDR_ONE;
                        beats_left_reg <= beats_left_reg - LEN_ONE;
                        if (beats_left_reg == '0) state_reg <= DONE;
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign request   = (state_reg == REQ) || (state_reg == BURST);
    assign mem_valid = (state_reg == BURST) && grant;
    assign mem_addr  = addr_reg;
    assign mem_last  = mem_valid && (beats_left_reg == '0);
    assign busy      = (state_reg != IDLE) || !fifo_empty;

`ifdef FB_REQ_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYCLES + 1);
    localparam logic [CW-1:0] TO_MAX = CW'(TO_CYCLES);
    localparam logic [CW-1:0] TO_PRE = CW'(TO_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = 1;

    logic [CW-1:0] wait_cnt_reg;
    logic          starve_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_reg <= '0;
            starve_reg   <= 1'b0;
        end else begin
            if ((state_reg == REQ) && !grant) begin
                if (wait_cnt_reg != TO_MAX) wait_cnt_reg <= wait_cnt_reg + CNT_ONE;
                if (wait_cnt_reg >= TO_PRE) starve_reg <= 1'b1;
            end else begin
                wait_cnt_reg <= '0;
            end
            if (grant) starve_reg <= 1'b0;
        end
    end

    // Masked by grant so the flag drops in the very cycle grant arrives.
    assign starve = starve_reg && !grant;
`else
    logic unused_timeout;
    assign unused_timeout = (TO_CYCLES != 0);
    assign starve         = 1'b0;
`endif

endmodule

// File: tb/tb_fb_req_client.sv
// Directed bench for fb_req_client: reset, burst timing, FIFO full, grant pause,
// address wrap, mid-burst reset and (with FB_REQ_TIMEOUT_EN) starvation flag.
module tb_fb_req_client;
    localparam int AW = 20;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          request;
    logic          grant = 1'b0;
    logic          mem_valid;
    logic [AW-1:0] mem_addr;
    logic          mem_last;
    logic          mem_ready = 1'b1;
    logic          busy;
    logic          starve;

    int total = 0;
    int bad = 0;

    logic [AW-1:0] cap_addr[$];
    logic          cap_last[$];

    fb_req_client #(.AW(AW), .LW(LW), .DEPTH(4), .TO_CYCLES(10)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .request(request), .grant(grant),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_last(mem_last), .mem_ready(mem_ready),
        .busy(busy), .starve(starve)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset && mem_valid && mem_ready) begin
            cap_addr.push_back(mem_addr);
            cap_last.push_back(mem_last);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while ((busy || request) && n < 100) begin
            tick;
            n++;
        end
        chk(tag, 32'(n < 100), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;

        // reset state
        repeat (2) tick;
        chk("rst_request", request, 0);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_mem_last", mem_last, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_starve", starve, 0);
        reset = 1'b1;
        tick;

        // single burst 0x100 len 3, grant two cycles after request
        cmd_valid = 1'b1; cmd_addr = 20'h00100; cmd_len = 8'd3;
        tick;
        cmd_valid = 1'b0;
        chk("t1_req_after_push", request, 0);
        chk("t1_busy_after_push", busy, 1);
        tick;
        chk("t1_req_rise", request, 1);
        chk("t1_valid_in_req", mem_valid, 0);
        tick;
        chk("t1_req_hold", request, 1);
        tick;
        grant = 1'b1;
        #1;
        chk("t1_valid_grant_req", mem_valid, 0);
        tick;
        for (int i = 0; i < 4; i++) begin
            chk("t1_beat_valid", mem_valid, 1);
            chk("t1_beat_addr", mem_addr, 32'h100 + 32'(i));
            chk("t1_beat_last", mem_last, 32'(i == 3));
            tick;
        end
        chk("t1_req_after", request, 0);
        chk("t1_valid_after", mem_valid, 0);
        grant = 1'b0;
        tick;
        chk("t1_req_low2", request, 0);
        chk("t1_beat_count", cap_addr.size(), 4);
        cap_addr.delete(); cap_last.delete();

        // FIFO fill: c0 occupies the FSM, c1..c5 pushed back-to-back
        cmd_valid = 1'b1; cmd_addr = 20'h00200; cmd_len = 8'd0;
        tick;
        for (int i = 1; i <= 4; i++) begin
            cmd_addr = 20'h00200 + AW'(i * 'h100);
            tick;
        end
        chk("t2_full_ready", cmd_ready, 0);
        cmd_addr = 20'h00700;
        tick;
        chk("t2_c5_refused", cmd_ready, 0);
        chk("t2_req_wait", request, 1);
        chk("t2_starve_short", starve, 0);
        grant = 1'b1;
        tick;
        chk("t2_c0_addr", mem_addr, 32'h200);
        chk("t2_c0_last", mem_last, 1);
        chk("t2_ready_burst", cmd_ready, 0);
        tick;
        chk("t2_done_req", request, 0);
        tick;
        chk("t2_idle_ready", cmd_ready, 0);
        tick;
        chk("t2_ready_after_pop", cmd_ready, 1);
        chk("t2_req_c1", request, 1);
        tick;
        chk("t2_ready_refull", cmd_ready, 0);
        cmd_valid = 1'b0;
        wait_done("t2_drain_timeout");
        chk("t2_beat_count", cap_addr.size(), 6);
        for (int i = 0; i < 6 && i < cap_addr.size(); i++) begin
            chk("t2_drain_addr", cap_addr[i], 32'h200 + 32'(i * 'h100));
            chk("t2_drain_last", cap_last[i], 1);
        end
        cap_addr.delete(); cap_last.delete();

        // grant dropped for 3 cycles mid-burst of 8 beats
        grant = 1'b0;
        cmd_valid = 1'b1; cmd_addr = 20'h01000; cmd_len = 8'd7;
        tick;
        cmd_valid = 1'b0;
        tick;
        grant = 1'b1;
        tick;
        chk("t3_first_addr", mem_addr, 32'h1000);
        tick;
        tick;
        grant = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t3_pause_valid", mem_valid, 0);
            chk("t3_pause_req", request, 1);
            chk("t3_pause_addr", mem_addr, 32'h1002);
            tick;
        end
        grant = 1'b1;
        #1;
        chk("t3_resume_valid", mem_valid, 1);
        wait_done("t3_timeout");
        chk("t3_beat_count", cap_addr.size(), 8);
        for (int i = 0; i < 8 && i < cap_addr.size(); i++) begin
            chk("t3_addr", cap_addr[i], 32'h1000 + 32'(i));
            chk("t3_last", cap_last[i], 32'(i == 7));
        end
        cap_addr.delete(); cap_last.delete();

        // address wrap at 2^AW
        cmd_valid = 1'b1; cmd_addr = 20'hFFFFE; cmd_len = 8'd2;
        tick;
        cmd_valid = 1'b0;
        wait_done("t4_timeout");
        chk("t4_beat_count", cap_addr.size(), 3);
        for (int i = 0; i < 3 && i < cap_addr.size(); i++) begin
            a = 20'hFFFFE + AW'(i);
            chk("t4_addr", cap_addr[i], a);
            chk("t4_last", cap_last[i], 32'(i == 2));
        end
        cap_addr.delete(); cap_last.delete();

        // reset during beat 2 of a 4-beat burst, two commands queued
        grant = 1'b0;
        cmd_valid = 1'b1; cmd_addr = 20'h02000; cmd_len = 8'd3;
        tick;
        cmd_addr = 20'h02100;
        tick;
        cmd_addr = 20'h02200;
        tick;
        cmd_valid = 1'b0;
        grant = 1'b1;
        tick;
        tick;
        chk("t5_beat2_addr", mem_addr, 32'h2001);
        reset = 1'b0;
        #1;
        chk("t5_rst_req", request, 0);
        chk("t5_rst_valid", mem_valid, 0);
        chk("t5_rst_last", mem_last, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_ready", cmd_ready, 1);
        cap_addr.delete(); cap_last.delete();
        tick;
        tick;
        reset = 1'b1;
        repeat (8) tick;
        chk("t5_no_beats", cap_addr.size(), 0);
        chk("t5_busy_after", busy, 0);
        chk("t5_req_after", request, 0);
        grant = 1'b0;

`ifdef FB_REQ_TIMEOUT_EN
        // starvation flag with TO_CYCLES = 10
        cmd_valid = 1'b1; cmd_addr = 20'h03000; cmd_len = 8'd0;
        tick;
        cmd_valid = 1'b0;
        tick;
        chk("t6_req", request, 1);
        repeat (9) tick;
        chk("t6_no_starve_9", starve, 0);
        tick;
        chk("t6_starve_10", starve, 1);
        tick;
        tick;
        chk("t6_starve_12", starve, 1);
        grant = 1'b1;
        #1;
        chk("t6_starve_clear", starve, 0);
        tick;
        chk("t6_starve_burst", starve, 0);
        wait_done("t6_timeout");
        grant = 1'b0;
        cap_addr.delete(); cap_last.delete();
`else
        chk("t6_starve_tied", starve, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
